// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
//   state_t   : FSM states IDLE -> RUN -> FIX -> DONE
//   MODE_*    : ctrl[1:0] sign-mode encodings, shared with the multiplier
//   DIV_WIDTH : default operand/result width
package div_pkg;

  localparam int DIV_WIDTH = 32;

  // 2'b01 behaves like MODE_SS (both operands signed).
  localparam logic [1:0] MODE_SS = 2'b00;
  localparam logic [1:0] MODE_SU = 2'b10;
  localparam logic [1:0] MODE_UU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: request/response bundle of the sequential divider.
//   start, a, b, ctrl                          : requester -> divider
//   quotient, remainder, busy, done, div_by_zero : divider -> requester
//
// Handshake: start is a request sampled only while the divider is idle
// (busy=0); there is no back-pressure and a start seen while busy is
// dropped. done is a one-cycle pulse; quotient/remainder/div_by_zero are
// valid from that cycle and hold until the next done or a reset.
interface div_seq_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       ctrl;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, a, b, ctrl,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, a, b, ctrl,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/div_seq_bkadder.sv
// bkadder: Brent-Kung parallel-prefix adder, sum = a + b + cin.
//   a, b : N-bit operands (N must be a power of two)
//   cin  : carry in
//   sum  : N-bit sum
//   cout : carry out of the MSB
module bkadder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  localparam int L = $clog2(N);

  // Stage 0 holds bit generate/propagate; stages 1..L are the up-sweep,
  // stages L+1..2L-1 the down-sweep. After the last stage g_s[.][i] is the
  // carry out of bit i (cin is folded into bit 0's generate).
  logic [N-1:0] g_s [0:2*L-1];
  logic [N-1:0] p_s [0:2*L-1];
  logic [N-1:0] g0;
  logic [N-1:0] carry;

  assign g0       = a & b;
  assign p_s[0]   = a ^ b;
  assign g_s[0]   = {g0[N-1:1], g0[0] | (p_s[0][0] & cin)};

  for (genvar l = 1; l <= L; l++) begin : g_up
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (((i + 1) % (1 << l)) == 0) begin : g_comb
        assign g_s[l][i] = g_s[l-1][i] | (p_s[l-1][i] & g_s[l-1][i-(1<<(l-1))]);
        assign p_s[l][i] = p_s[l-1][i] & p_s[l-1][i-(1<<(l-1))];
      end else begin : g_pass
        assign g_s[l][i] = g_s[l-1][i];
        assign p_s[l][i] = p_s[l-1][i];
      end
    end
  end

  for (genvar d = 1; d < L; d++) begin : g_down
    localparam int LV = L - d;
    for (genvar i = 0; i < N; i++) begin : g_bit
      if ((i >= (1 << LV)) && (((i + 1) % (1 << LV)) == (1 << (LV - 1)))) begin : g_comb
        assign g_s[L+d][i] = g_s[L+d-1][i] | (p_s[L+d-1][i] & g_s[L+d-1][i-(1<<(LV-1))]);
        assign p_s[L+d][i] = p_s[L+d-1][i] & p_s[L+d-1][i-(1<<(LV-1))];
      end else begin : g_pass
        assign g_s[L+d][i] = g_s[L+d-1][i];
        assign p_s[L+d][i] = p_s[L+d-1][i];
      end
    end
  end

  assign carry = g_s[2*L-1];
  assign sum   = p_s[0] ^ {carry[N-2:0], cin};
  assign cout  = carry[N-1];
endmodule

// File: rtl/div_seq.sv
// div_seq: iterative restoring divider, one quotient bit per clock.
//   clk, rst : clock, synchronous active-high reset
//   bus      : div_seq_if slave (start/a/b/ctrl in; quotient/remainder/
//              busy/done/div_by_zero out)
//   state_o  : current FSM state, for observation
// Start accepted at edge N gives done high after edge N+WIDTH+2.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  div_seq_if.slave    bus,
  output state_t      state_o
);
  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder, later fixed remainder
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rmdr_q, rmdr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] rem_sh, diff;
  logic             cout, sub_ok;

  assign sign_a = (bus.ctrl[1:0] != MODE_UU) && bus.a[WIDTH-1];
  assign sign_b = (bus.ctrl[1:0] != MODE_UU) && (bus.ctrl[1:0] != MODE_SU) && bus.b[WIDTH-1];
  assign abs_a  = sign_a ? (~bus.a + WIDTH'(1)) : bus.a;
  assign abs_b  = sign_b ? (~bus.b + WIDTH'(1)) : bus.b;

  // The shifted remainder is WIDTH+1 bits wide; its top bit is rem_q's MSB.
  // When that bit is set the trial subtraction cannot borrow, and the true
  // difference still fits in WIDTH bits because it is below the divisor.
  assign rem_sh = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign sub_ok = rem_q[WIDTH-1] | cout;

  bkadder #(.N(WIDTH)) u_sub (
    .a    (rem_sh),
    .b    (~dvs_q),
    .cin  (1'b1),
    .sum  (diff),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rmdr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rmdr_q  <= rmdr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rmdr_d  = rmdr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          count_d = '0;
          rem_d   = '0;
          dvd_d   = abs_a;
          dvs_d   = abs_b;
          negq_d  = sign_a ^ sign_b;
          negr_d  = sign_a;
          dz_d    = (bus.b == '0);
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        rem_d   = sub_ok ? diff : rem_sh;
        dvd_d   = {dvd_q[WIDTH-2:0], sub_ok};
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        // With a zero divisor every trial succeeds, so the magnitude
        // quotient is all ones and the magnitude remainder is |a|;
        // re-applying a's sign to it restores a unmodified.
        if (dz_q) dvd_d = '1;
        else      dvd_d = negq_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
        rem_d   = negr_q ? (~rem_q + WIDTH'(1)) : rem_q;
        state_d = DONE;
      end
      DONE: begin
        quot_d  = dvd_q;
        rmdr_d  = rem_q;
        dbz_d   = dz_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.quotient    = quot_q;
  assign bus.remainder   = rmdr_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign state_o         = state_q;
endmodule
